// File: rtl/rst_seq_pkg.sv
// Shared state encoding, default parameter values and counter-width helper
// for the reset sequencer slice.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_RELEASE   = 3'd1,
    ST_RUN       = 3'd2,
    ST_ASSERT    = 3'd3,
    ST_HOLD      = 3'd4,
    ST_ACK       = 3'd5
  } seq_state_e;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_LOCK_CYCLES = 16;
  localparam int DEF_STAGE_GAP   = 8;
  localparam int DEF_HOLD_CYCLES = 4;

  // Bits needed to hold every value 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// Lock qualifier: counts consecutive LOCK=1 samples and flags the edge on
// which the LOCK_CYCLES-th consecutive high sample is taken.
module lock_filter
  import rst_seq_pkg::*;
#(
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic LOCK,
  input  logic clear,
  output logic qualified
);

  localparam int CNT_W = cnt_width(LOCK_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating run-length counter; any low sample or clear restarts the run.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !LOCK) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_W'(LOCK_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Combinational so the sequencer can act on the very edge that completes the run.
  assign qualified = LOCK & ~clear & (cnt_q >= CNT_W'(LOCK_CYCLES - 1));

  // Counter register.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: qualifies lock, releases stage resets in order with a fixed
// gap, and runs the 4-phase software reset handshake with reverse-order assert.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int STAGE_GAP   = DEF_STAGE_GAP,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  LOCK,
  input  logic                  SW_REQ,
  output logic                  SW_ACK,
  output logic [NUM_STAGES-1:0] STAGE_RST_N,
  output logic                  READY
);

  localparam int GAP_W  = cnt_width(STAGE_GAP);
  localparam int IDX_W  = cnt_width(NUM_STAGES);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);

  seq_state_e            state_q, state_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic                  lock_qual_s;

  lock_filter #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock_filter (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .LOCK     (LOCK),
    .clear    (state_q != ST_WAIT_LOCK),
    .qualified(lock_qual_s)
  );

  // idx_q counts released stages; gap_q/hold_q time the spacing between edges.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    ready_d = ready_q;
    ack_d   = ack_q;
    if ((state_q != ST_WAIT_LOCK) && !LOCK) begin
      state_d = ST_WAIT_LOCK;
      stage_d = '0;
      idx_d   = '0;
      gap_d   = '0;
      hold_d  = '0;
      ready_d = 1'b0;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (lock_qual_s) begin
            stage_d = STAGE_ONE;
            idx_d   = IDX_W'(1);
            gap_d   = '0;
            state_d = ST_RELEASE;
          end else begin
            stage_d = '0;
            ready_d = 1'b0;
            ack_d   = 1'b0;
          end
        end
        ST_RELEASE: begin
          if (idx_q == IDX_W'(NUM_STAGES)) begin
            ready_d = 1'b1;
            state_d = ST_RUN;
          end else if (gap_q == GAP_W'(STAGE_GAP - 1)) begin
            stage_d = stage_q | (STAGE_ONE << idx_q);
            idx_d   = idx_q + IDX_W'(1);
            gap_d   = '0;
          end else begin
            gap_d   = gap_q + GAP_W'(1);
          end
        end
        ST_RUN: begin
          if (SW_REQ) begin
            ready_d                 = 1'b0;
            stage_d[NUM_STAGES-1]   = 1'b0;
            idx_d                   = IDX_W'(NUM_STAGES - 1);
            gap_d                   = '0;
            hold_d                  = '0;
            state_d = (NUM_STAGES == 1) ? ST_HOLD : ST_ASSERT;
          end else begin
            ready_d = 1'b1;
          end
        end
        ST_ASSERT: begin
          if (gap_q == GAP_W'(STAGE_GAP - 1)) begin
            stage_d = stage_q & ~(STAGE_ONE << (idx_q - IDX_W'(1)));
            idx_d   = idx_q - IDX_W'(1);
            gap_d   = '0;
            hold_d  = '0;
            state_d = (idx_q == IDX_W'(1)) ? ST_HOLD : ST_ASSERT;
          end else begin
            gap_d   = gap_q + GAP_W'(1);
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            ack_d   = 1'b1;
            state_d = ST_ACK;
          end else begin
            hold_d  = hold_q + HOLD_W'(1);
          end
        end
        ST_ACK: begin
          if (!SW_REQ) begin
            ack_d   = 1'b0;
            hold_d  = '0;
            state_d = ST_WAIT_LOCK;
          end else begin
            ack_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          stage_d = '0;
          idx_d   = '0;
          gap_d   = '0;
          hold_d  = '0;
          ready_d = 1'b0;
          ack_d   = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_WAIT_LOCK;
      stage_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  assign STAGE_RST_N = stage_q;
  assign READY       = ready_q;
  assign SW_ACK      = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios with literal expectations,
// then randomized LOCK/SW_REQ/RESET against an elapsed-time reference model.
module tb_reset_sequencer;

  localparam int N  = 4;
  localparam int LC = 16;
  localparam int G  = 8;
  localparam int H  = 4;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_RUN  = 2;
  localparam int M_DOWN = 3;
  localparam int M_ACK  = 4;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b0;
  logic         LOCK = 1'b0;
  logic         SW_REQ = 1'b0;
  logic         SW_ACK;
  logic [N-1:0] STAGE_RST_N;
  logic         READY;

  reset_sequencer #(
    .NUM_STAGES (N),
    .LOCK_CYCLES(LC),
    .STAGE_GAP  (G),
    .HOLD_CYCLES(H)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .LOCK       (LOCK),
    .SW_REQ     (SW_REQ),
    .SW_ACK     (SW_ACK),
    .STAGE_RST_N(STAGE_RST_N),
    .READY      (READY)
  );

  always #5 CLOCK = ~CLOCK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase plus edge of the phase's starting event.
  int           mode, runlen, t_ev, e;
  logic [N-1:0] m_stage;
  logic         m_ready, m_ack;
  logic         rq_r, lk_r;

  task automatic model_reset();
    mode = M_IDLE; runlen = 0; t_ev = 0; e = 0;
    m_stage = '0; m_ready = 1'b0; m_ack = 1'b0;
  endtask

  task automatic model_step(input logic lk, input logic rq);
    int d, n;
    e++;
    if (mode != M_IDLE && !lk) begin
      mode = M_IDLE; runlen = 0;
    end else begin
      case (mode)
        M_IDLE: begin
          runlen = lk ? ((runlen < LC) ? runlen + 1 : LC) : 0;
          if (runlen == LC) begin mode = M_UP; t_ev = e; runlen = 0; end
        end
        M_UP:   if (e - t_ev == (N - 1) * G + 1) mode = M_RUN;
        M_RUN:  if (rq) begin mode = M_DOWN; t_ev = e; end
        M_DOWN: if (e - t_ev == (N - 1) * G + H) mode = M_ACK;
        M_ACK:  if (!rq) mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
    end
    d = e - t_ev;
    m_stage = '0; m_ready = 1'b0; m_ack = 1'b0;
    case (mode)
      M_UP:   begin n = d / G + 1; if (n > N) n = N; m_stage = N'((1 << n) - 1); end
      M_RUN:  begin m_stage = '1; m_ready = 1'b1; end
      M_DOWN: begin n = d / G + 1; if (n > N) n = N; m_stage = N'((1 << (N - n)) - 1); end
      M_ACK:  m_ack = 1'b1;
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, e);
    end
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] exp);
    chk({name, "_dut"}, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask

  // One clock: drive at negedge, step model, compare after posedge.
  task automatic cyc(input logic lk, input logic rq);
    LOCK = lk; SW_REQ = rq;
    model_step(lk, rq);
    @(posedge CLOCK); #1;
    chk("stage_rst_n", STAGE_RST_N, m_stage);
    chk("ready", READY, m_ready);
    chk("sw_ack", SW_ACK, m_ack);
    @(negedge CLOCK);
  endtask

  task automatic run(input int n, input logic lk, input logic rq);
    for (int i = 0; i < n; i++) cyc(lk, rq);
  endtask

  // Async reset pulled between clock edges; outputs must clear with no clock.
  task automatic areset();
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    chk("areset_stage", STAGE_RST_N, 32'd0);
    chk("areset_ready", READY, 32'd0);
    chk("areset_ack", SW_ACK, 32'd0);
    @(negedge CLOCK);
    RESET = 1'b1;
  endtask

  initial begin
    model_reset();
    rq_r = 1'b0;
    lk_r = 1'b0;
    @(negedge CLOCK);
    chk("reset_stage", STAGE_RST_N, 32'd0);
    chk("reset_ready", READY, 32'd0);
    chk("reset_ack", SW_ACK, 32'd0);
    @(negedge CLOCK);
    RESET = 1'b1;

    // Power-up release with LOCK high from the first edge.
    run(15, 1'b1, 1'b0);  lit("t1_e15", STAGE_RST_N, m_stage, 32'h0);
    cyc(1'b1, 1'b0);      lit("t1_e16", STAGE_RST_N, m_stage, 32'h1);
    run(7, 1'b1, 1'b0);   lit("t1_e23", STAGE_RST_N, m_stage, 32'h1);
    cyc(1'b1, 1'b0);      lit("t1_e24", STAGE_RST_N, m_stage, 32'h3);
    run(8, 1'b1, 1'b0);   lit("t1_e32", STAGE_RST_N, m_stage, 32'h7);
    run(8, 1'b1, 1'b0);   lit("t1_e40", STAGE_RST_N, m_stage, 32'hf);
                          lit("t1_e40_rdy", READY, m_ready, 32'h0);
    cyc(1'b1, 1'b0);      lit("t1_e41_rdy", READY, m_ready, 32'h1);

    // Software reset handshake.
    run(4, 1'b1, 1'b0);
    cyc(1'b1, 1'b1);      lit("t3_s", STAGE_RST_N, m_stage, 32'h7);
                          lit("t3_s_rdy", READY, m_ready, 32'h0);
    run(8, 1'b1, 1'b1);   lit("t3_s8", STAGE_RST_N, m_stage, 32'h3);
    run(8, 1'b1, 1'b1);   lit("t3_s16", STAGE_RST_N, m_stage, 32'h1);
    run(8, 1'b1, 1'b1);   lit("t3_s24", STAGE_RST_N, m_stage, 32'h0);
    run(3, 1'b1, 1'b1);   lit("t3_s27_ack", SW_ACK, m_ack, 32'h0);
    cyc(1'b1, 1'b1);      lit("t3_s28_ack", SW_ACK, m_ack, 32'h1);
    run(2, 1'b1, 1'b1);   lit("t3_ack_held", SW_ACK, m_ack, 32'h1);
    cyc(1'b1, 1'b0);      lit("t3_ack_drop", SW_ACK, m_ack, 32'h0);
    run(15, 1'b1, 1'b0);  lit("t3_requal15", STAGE_RST_N, m_stage, 32'h0);
    cyc(1'b1, 1'b0);      lit("t3_requal16", STAGE_RST_N, m_stage, 32'h1);

    // Lock loss during RELEASE.
    run(8, 1'b1, 1'b0);   lit("t4_rel_0011", STAGE_RST_N, m_stage, 32'h3);
    cyc(1'b0, 1'b0);      lit("t4_rel_loss", STAGE_RST_N, m_stage, 32'h0);

    // Lock dip restarts qualification.
    run(10, 1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    run(15, 1'b1, 1'b0);  lit("t2_dip15", STAGE_RST_N, m_stage, 32'h0);
    cyc(1'b1, 1'b0);      lit("t2_dip16", STAGE_RST_N, m_stage, 32'h1);

    // Lock loss during HOLD drops the request.
    run(25, 1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    run(26, 1'b1, 1'b1);
    cyc(1'b0, 1'b1);      lit("t4_hold_loss", STAGE_RST_N, m_stage, 32'h0);
                          lit("t4_hold_ack", SW_ACK, m_ack, 32'h0);

    // Request held through re-release: READY pulses for one cycle.
    run(16, 1'b1, 1'b1);  lit("t6_t0", STAGE_RST_N, m_stage, 32'h1);
    run(25, 1'b1, 1'b1);  lit("t6_rdy", READY, m_ready, 32'h1);
    cyc(1'b1, 1'b1);      lit("t6_rdy_drop", READY, m_ready, 32'h0);
                          lit("t6_assert", STAGE_RST_N, m_stage, 32'h7);

    // Async reset mid-ASSERT, then a clean restart.
    run(3, 1'b1, 1'b1);
    areset();
    run(15, 1'b1, 1'b0);  lit("t5_restart15", STAGE_RST_N, m_stage, 32'h0);
    cyc(1'b1, 1'b0);      lit("t5_restart16", STAGE_RST_N, m_stage, 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        areset();
      end else begin
        lk_r = ($urandom_range(0, 299) != 0);
        if ($urandom_range(0, 29) == 0) rq_r = ~rq_r;
        cyc(lk_r, rq_r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
